// File: rtl/bank_pkg.sv
// -----------------------------------------------------------------------------
// bank_pkg
// Shared definitions for the counter dispatch block: default widths for the
// customer number and service time, the service-counter state encoding, and a
// saturating 8-bit accumulate helper used by the statistics counters.
// No ports (package).
// -----------------------------------------------------------------------------
package bank_pkg;

  localparam int NUM_W_DEF  = 4;
  localparam int TIME_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } ctr_state_e;

  // a + b, clamped at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/service_counter.sv
// -----------------------------------------------------------------------------
// service_counter
// One service counter: IDLE/SERVE state machine holding the customer number
// and remaining service time, plus a one-cycle completion pulse.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   tick_i   : service time unit pulse; only a SERVE counter reacts
//   load_i   : dispatch strobe; only ever asserted while this counter is IDLE
//   num_i    : customer number to latch on load
//   time_i   : service time to latch on load (0 is treated as 1)
//   state_o  : current state (busy == SERVE)
//   cnum_o   : customer number, held after completion until the next load
//   crem_o   : remaining service time, 0 while IDLE
//   done_o   : high for the cycle after crem reaches 0
// -----------------------------------------------------------------------------
module service_counter
  import bank_pkg::*;
#(
  parameter int NUM_W  = NUM_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [NUM_W-1:0]  num_i,
  input  logic [TIME_W-1:0] time_i,
  output ctr_state_e        state_o,
  output logic [NUM_W-1:0]  cnum_o,
  output logic [TIME_W-1:0] crem_o,
  output logic              done_o
);

  ctr_state_e        state_q;
  logic [NUM_W-1:0]  cnum_q;
  logic [TIME_W-1:0] crem_q;
  logic [TIME_W-1:0] crem_ld_d;
  logic              done_q;

  // A zero service time still occupies the counter for one tick.
  assign crem_ld_d = (time_i == '0) ? TIME_W'(1) : time_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnum_q  <= '0;
      crem_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Tick is ignored here, so a load on a tick cycle is not decremented.
        IDLE: begin
          if (load_i) begin
            state_q <= SERVE;
            cnum_q  <= num_i;
            crem_q  <= crem_ld_d;
          end
        end
        SERVE: begin
          if (tick_i) begin
            crem_q <= crem_q - TIME_W'(1);
            if (crem_q == TIME_W'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign cnum_o  = cnum_q;
  assign crem_o  = crem_q;
  assign done_o  = done_q;

endmodule

// File: rtl/counter_dispatch.sv
// -----------------------------------------------------------------------------
// counter_dispatch
// Dispatches customers from the head of an external queue to NCTR service
// counters. Each cycle at most one customer is handed to the lowest-index idle
// counter. Optional statistics are built only when DISPATCH_STATS_EN is defined;
// otherwise served/stall are tied to 0.
//
// Handshake: re is a combinational dequeue strobe. When re=1 in a cycle, the
// queue head (qn/qt) is consumed at the next rising edge by the selected
// counter and the queue must present the next entry afterwards.
//
// Ports
//   clk, rst_n  : clock / asynchronous active-low reset
//   tick        : one-cycle service time unit pulse
//   open        : dispatch enable (service continues when low)
//   qn, qt      : customer number / service time at queue head
//   empty       : queue has no entries
//   re          : dequeue strobe
//   busy        : per-counter occupied flag
//   cnum, crem  : per-counter number / remaining time, counter 0 in LSBs
//   done        : per-counter completion pulse
//   served      : completed customers, saturating (stats build)
//   stall       : cycles with waiting customers and no idle counter (stats build)
// -----------------------------------------------------------------------------
module counter_dispatch
  import bank_pkg::*;
#(
  parameter int NCTR   = 2,
  parameter int NUM_W  = NUM_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     open,
  input  logic [NUM_W-1:0]         qn,
  input  logic [TIME_W-1:0]        qt,
  input  logic                     empty,
  output logic                     re,
  output logic [NCTR-1:0]          busy,
  output logic [NCTR*NUM_W-1:0]    cnum,
  output logic [NCTR*TIME_W-1:0]   crem,
  output logic [NCTR-1:0]          done,
  output logic [7:0]               served,
  output logic [7:0]               stall
);

  logic [NCTR-1:0] idle;
  logic [NCTR-1:0] pick;
  logic [NCTR-1:0] load;

  // busy reflects start-of-cycle state, so a counter freed at an edge only
  // becomes selectable in the following cycle.
  assign idle = ~busy;
  assign re   = rst_n & open & ~empty & (|idle);
  // Isolate the lowest set bit: lowest-index idle counter.
  assign pick = idle & (~idle + NCTR'(1));
  assign load = re ? pick : '0;

  for (genvar i = 0; i < NCTR; i++) begin : g_ctr
    ctr_state_e st;

    service_counter #(
      .NUM_W  (NUM_W),
      .TIME_W (TIME_W)
    ) u_ctr (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .tick_i  (tick),
      .load_i  (load[i]),
      .num_i   (qn),
      .time_i  (qt),
      .state_o (st),
      .cnum_o  (cnum[i*NUM_W +: NUM_W]),
      .crem_o  (crem[i*TIME_W +: TIME_W]),
      .done_o  (done[i])
    );

    assign busy[i] = (st == SERVE);
  end

`ifdef DISPATCH_STATS_EN
  logic [7:0] served_q;
  logic [7:0] stall_q;
  logic [2:0] done_cnt;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NCTR; i++) begin
      done_cnt = done_cnt + {2'b00, done[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= '0;
      stall_q  <= '0;
    end else begin
      served_q <= sat_add8(served_q, done_cnt);
      stall_q  <= sat_add8(stall_q, {2'b00, ~empty & ~(|idle)});
    end
  end

  assign served = served_q;
  assign stall  = stall_q;
`else
  assign served = '0;
  assign stall  = '0;
`endif

endmodule
